// File: rtl/mem_access_ctrl_if.sv
// SRAM half-word bus between mem_access_ctrl (master) and the external SRAM (slave).
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 18
);
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_o;
   logic [15:0]       sram_dq_i;
   logic              sram_dq_oe;
   logic              sram_we_n;

   modport master (
      output sram_addr, sram_dq_o, sram_dq_oe, sram_we_n,
      input  sram_dq_i
   );

   modport slave (
      input  sram_addr, sram_dq_o, sram_dq_oe, sram_we_n,
      output sram_dq_i
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data access sequencer: one 32-bit load/store as two 16-bit SRAM phases,
// with superStall freezing the pipeline. Define MEM_CTRL_POSTED_WRITE_EN for posted stores.
module mem_access_ctrl #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_STATES = 1,
   parameter int BASE_ADDR   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_En,
   input  logic              MEM_W_En,
   input  logic [31:0]       ALU_result,
   input  logic [31:0]       ST_val,
   output logic [31:0]       rdata,
   output logic              superStall,
   mem_access_ctrl_if.master sram
);
   localparam int            CW      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int            WW      = ADDR_W - 1;
   localparam logic [CW-1:0] LAST    = CW'(WAIT_STATES);
   localparam bit            NO_WAIT = (WAIT_STATES == 0);
`ifdef MEM_CTRL_POSTED_WRITE_EN
   localparam bit            POSTED  = 1'b1;
`else
   localparam bit            POSTED  = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [WW-1:0]   word_q, word_in;
   logic [31:0]     data_q;
   logic            req, last, latch, cap_lo, cap_hi, wr_stall;
   logic [ADDR_W-1:0] addr_c;
   logic [15:0]     dq_c;
   logic            oe_c, we_n_c, stall_c;

   assign word_in  = WW'((ALU_result - 32'(BASE_ADDR)) >> 2);
   assign req      = rst & (MEM_R_En | MEM_W_En);
   assign last     = (cnt == LAST);
   // A posted store only stalls the pipeline once the next instruction asks for memory.
   assign wr_stall = POSTED ? (MEM_R_En | MEM_W_En) : 1'b1;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      latch    = 1'b0;
      cap_lo   = 1'b0;
      cap_hi   = 1'b0;
      addr_c   = {word_q, 1'b0};
      dq_c     = data_q[15:0];
      oe_c     = 1'b0;
      we_n_c   = 1'b1;
      stall_c  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               // The request cycle is the first LO phase cycle, so the counter leaves IDLE at 1.
               latch  = 1'b1;
               addr_c = {word_in, 1'b0};
               cnt_nx = NO_WAIT ? '0 : CW'(1);
               if (MEM_R_En) begin
                  stall_c  = 1'b1;
                  cap_lo   = NO_WAIT;
                  state_nx = NO_WAIT ? RD_HI : RD_LO;
               end else begin
                  oe_c     = 1'b1;
                  we_n_c   = 1'b0;
                  dq_c     = ST_val[15:0];
                  stall_c  = !POSTED;
                  state_nx = NO_WAIT ? WR_HI : WR_LO;
               end
            end
         end
         RD_LO: begin
            stall_c = 1'b1;
            if (last) begin
               cap_lo   = 1'b1;
               cnt_nx   = '0;
               state_nx = RD_HI;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         RD_HI: begin
            stall_c = 1'b1;
            addr_c  = {word_q, 1'b1};
            if (last) begin
               cap_hi   = 1'b1;
               cnt_nx   = '0;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WR_LO: begin
            stall_c = wr_stall;
            oe_c    = 1'b1;
            we_n_c  = 1'b0;
            if (last) begin
               cnt_nx   = '0;
               state_nx = WR_HI;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         WR_HI: begin
            stall_c = wr_stall;
            addr_c  = {word_q, 1'b1};
            dq_c    = data_q[31:16];
            oe_c    = 1'b1;
            we_n_c  = 1'b0;
            if (last) begin
               cnt_nx   = '0;
               state_nx = POSTED ? IDLE : DONE;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         cnt    <= '0;
         word_q <= '0;
         data_q <= '0;
         rdata  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (latch) begin
            word_q <= word_in;
            data_q <= ST_val;
         end
         if (cap_lo) rdata[15:0]  <= sram.sram_dq_i;
         if (cap_hi) rdata[31:16] <= sram.sram_dq_i;
      end
   end

   assign superStall      = stall_c;
   assign sram.sram_addr  = addr_c;
   assign sram.sram_dq_o  = dq_c;
   assign sram.sram_dq_oe = oe_c;
   assign sram.sram_we_n  = we_n_c;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then pipeline-like random traffic.
module tb_mem_access_ctrl;
   localparam int ADDR_W = 18;
   localparam int WS     = 1;
   localparam int P      = WS + 1;
`ifdef MEM_CTRL_POSTED_WRITE_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_En, MEM_W_En;
   logic [31:0] ALU_result, ST_val;
   logic [31:0] rdata;
   logic        superStall;
   logic        preload;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) sif ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .WAIT_STATES(WS), .BASE_ADDR(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .MEM_R_En   (MEM_R_En),
      .MEM_W_En   (MEM_W_En),
      .ALU_result (ALU_result),
      .ST_val     (ST_val),
      .rdata      (rdata),
      .superStall (superStall),
      .sram       (sif)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      if (i == 2) return 16'h1234;
      if (i == 3) return 16'hABCD;
      return 16'(i * 977 + 16'h3C5A);
   endfunction

   // SRAM: combinational read, write on the clock while we_n is low.
   logic [15:0] mem [0:63];
   assign sif.sram_dq_i = mem[sif.sram_addr[5:0]];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else if (!sif.sram_we_n) begin
         mem[sif.sram_addr[5:0]] <= sif.sram_dq_o;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: an access is a run of 2P cycles starting on the accept cycle.
   logic [15:0] exp_mem [0:63];
   bit          m_active, m_done, m_read;
   int          m_k;
   logic [16:0] m_word;
   logic [31:0] m_data, m_rd_word, m_rdata;

   task automatic model_check();
      logic        half;
      logic [17:0] ea;
      logic [15:0] ed;
      if (preload) for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
      if (!rst) begin
         m_active = 0; m_done = 0; m_rdata = '0;
         check("rst_stall", superStall, 0);
         check("rst_we_n", sif.sram_we_n, 1);
         check("rst_oe", sif.sram_dq_oe, 0);
         check("rst_addr", sif.sram_addr, 0);
         check("rst_dq_o", sif.sram_dq_o, 0);
         check("rst_rdata", rdata, 0);
         return;
      end
      if (!m_active && !m_done && (MEM_R_En || MEM_W_En)) begin
         m_active  = 1;
         m_k       = 0;
         m_read    = MEM_R_En;
         m_word    = 17'((ALU_result - 32'd1024) >> 2);
         m_data    = ST_val;
         m_rd_word = {exp_mem[{m_word[4:0], 1'b1}], exp_mem[{m_word[4:0], 1'b0}]};
      end
      if (m_active) begin
         half = (m_k >= P);
         ea   = {m_word, half};
         ed   = half ? m_data[31:16] : m_data[15:0];
         check("addr", sif.sram_addr, ea);
         if (m_read) begin
            check("rd_we_n", sif.sram_we_n, 1);
            check("rd_oe", sif.sram_dq_oe, 0);
            check("rd_stall", superStall, 1);
         end else begin
            check("wr_we_n", sif.sram_we_n, 0);
            check("wr_oe", sif.sram_dq_oe, 1);
            check("wr_dq_o", sif.sram_dq_o, ed);
            check("wr_stall", superStall,
                  POSTED ? 32'((m_k > 0) && (MEM_R_En || MEM_W_En)) : 32'd1);
            exp_mem[ea[5:0]] = ed;
         end
         m_k++;
         if (m_k == 2 * P) begin
            m_active = 0;
            m_done   = m_read || !POSTED;
            if (m_read) m_rdata = m_rd_word;
         end
      end else begin
         check("idle_stall", superStall, 0);
         check("idle_we_n", sif.sram_we_n, 1);
         check("idle_oe", sif.sram_dq_oe, 0);
         check("rdata", rdata, m_rdata);
         m_done = 0;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      model_check();
   endtask

   logic        tr_stall [0:63];
   logic        tr_we    [0:63];
   logic [17:0] tr_addr  [0:63];
   logic [31:0] tr_rdata [0:63];
   int          n_tr;

   function automatic int stall_count();
      int c = 0;
      for (int i = 0; i < n_tr; i++) if (tr_stall[i]) c++;
      return c;
   endfunction

   function automatic int we_count();
      int c = 0;
      for (int i = 0; i < n_tr; i++) if (!tr_we[i]) c++;
      return c;
   endfunction

   // Present one instruction and hold it while the pipeline is frozen.
   task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      MEM_R_En = r; MEM_W_En = w; ALU_result = a; ST_val = d;
      n_tr = 0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         tr_stall[n_tr] = superStall;
         tr_we[n_tr]    = sif.sram_we_n;
         tr_addr[n_tr]  = sif.sram_addr;
         tr_rdata[n_tr] = rdata;
         n_tr++;
         if (!superStall) break;
         @(posedge clk); #1;
      end
      check("issue_released", tr_stall[n_tr-1], 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         MEM_R_En = 0; MEM_W_En = 0;
         cyc();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      bit hold;
      int x;
      rst = 1; preload = 1;
      MEM_R_En = 0; MEM_W_En = 0; ALU_result = '0; ST_val = '0;
      m_active = 0; m_done = 0; m_read = 0; m_k = 0;
      m_word = '0; m_data = '0; m_rd_word = '0; m_rdata = '0;
      #2 rst = 0;
      for (int i = 0; i < 3; i++) cyc();
      @(posedge clk); #1;
      preload = 0; rst = 1;
      cyc();

      // Load at 1028: half-words 2 and 3.
      issue(1, 0, 32'd1028, '0);
      check("ld_len", n_tr, 5);
      check("ld_addr0", tr_addr[0], 2);
      check("ld_addr1", tr_addr[1], 2);
      check("ld_addr2", tr_addr[2], 3);
      check("ld_addr3", tr_addr[3], 3);
      check("ld_stall", stall_count(), 4);
      check("ld_rdata", tr_rdata[n_tr-1], 32'hABCD1234);
      idle(1);

`ifdef MEM_CTRL_POSTED_WRITE_EN
      issue(0, 1, 32'd1032, 32'hDEADBEEF);
      check("pst_len", n_tr, 1);
      check("pst_stall0", tr_stall[0], 0);
      check("pst_we0", tr_we[0], 0);
      issue(1, 0, 32'd1032, '0);
      check("pst_ld_len", n_tr, 8);
      check("pst_ld_stall", stall_count(), 7);
      check("pst_ld_we", we_count(), 3);
      check("pst_ld_rdata", tr_rdata[n_tr-1], 32'hDEADBEEF);
      idle(1);
`else
      issue(0, 1, 32'd1032, 32'hDEADBEEF);
      check("st_len", n_tr, 5);
      check("st_stall", stall_count(), 4);
      check("st_we", we_count(), 4);
      idle(1);
`endif
      check("st_mem4", mem[4], 16'hBEEF);
      check("st_mem5", mem[5], 16'hDEAD);

      // Reset pulse in the middle of the high read phase.
      @(posedge clk); #1;
      MEM_R_En = 1; ALU_result = 32'd1028;
      cyc();
      @(posedge clk); #1;
      cyc();
      @(posedge clk); #1;
      #2 rst = 0;
      #1;
      check("arst_stall", superStall, 0);
      check("arst_we_n", sif.sram_we_n, 1);
      check("arst_oe", sif.sram_dq_oe, 0);
      check("arst_addr", sif.sram_addr, 0);
      check("arst_dq_o", sif.sram_dq_o, 0);
      check("arst_rdata", rdata, 0);
      MEM_R_En = 0;
      cyc();
      @(posedge clk); #1;
      rst = 1;
      cyc();
      issue(1, 0, 32'd1028, '0);
      check("rld_len", n_tr, 2 * P + 1);
      check("rld_stall", stall_count(), 4);
      check("rld_rdata", tr_rdata[n_tr-1], 32'hABCD1234);
      idle(1);

      // Read and write requested together: the read wins.
      issue(1, 1, 32'd1028, 32'h5555AAAA);
      check("rw_len", n_tr, 5);
      check("rw_we", we_count(), 0);
      check("rw_rdata", tr_rdata[n_tr-1], 32'hABCD1234);
      idle(1);
      check("rw_mem2", mem[2], 16'h1234);
      check("rw_mem3", mem[3], 16'hABCD);

      // Back-to-back loads.
      issue(1, 0, 32'd1028, '0);
      check("b2b1_len", n_tr, 5);
      check("b2b1_stall", stall_count(), 4);
      issue(1, 0, 32'd1032, '0);
      check("b2b2_len", n_tr, 5);
      check("b2b2_stall", stall_count(), 4);
      check("b2b2_addr0", tr_addr[0], 4);
      check("b2b2_rdata", tr_rdata[n_tr-1], 32'hDEADBEEF);
      idle(1);

      // Random traffic with pipeline-like holding while stalled.
      hold = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (!hold) begin
            x = $urandom_range(0, 9);
            MEM_R_En   = (x <= 3) || (x == 8);
            MEM_W_En   = (x >= 4) && (x <= 8);
            ALU_result = 32'd1024 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            ST_val     = $urandom;
         end
         cyc();
         hold = superStall;
      end
      idle(8);
      for (int i = 0; i < 32; i++) check($sformatf("mem%0d", i), mem[i], exp_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
